// File: rtl/zero_det_seq_ctrl.sv
// Sequencer feeding a serial zero_detector: clears it, shifts a word in, counts Mealy hits.
// Optional build macro ZDC_LSB_FIRST_EN selects LSB-first shifting (default MSB-first).
module zero_det_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
) (
  input  logic             CLOCK,
  input  logic             t_reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] word_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             y_in,
  output logic             x_out,
  output logic             det_rst_n,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] zero_count
);

  typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [LEN_W-1:0] bit_cnt;
  logic [LEN_W-1:0] len_clamp;

  assign len_clamp = (len_in > WIDTH_L) ? WIDTH_L : len_in;

  always_ff @(posedge CLOCK or negedge t_reset) begin
    if (!t_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLR;
      CLR: begin
        if (abort)                 state_nxt = IDLE;
        else if (bit_cnt != '0)    state_nxt = SHIFT;
        else                       state_nxt = DONE;
      end
      SHIFT: begin
        if (abort)                         state_nxt = IDLE;
        else if (bit_cnt == LEN_W'(1))     state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // y_in is sampled in the same cycle as the bit it responds to
  always_ff @(posedge CLOCK or negedge t_reset) begin
    if (!t_reset) begin
      sreg       <= '0;
      bit_cnt    <= '0;
      zero_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sreg       <= word_in;
            bit_cnt    <= len_clamp;
            zero_count <= '0;
          end
        end
        CLR: begin
          if (abort) zero_count <= '0;
        end
        SHIFT: begin
          if (abort) begin
            zero_count <= '0;
            bit_cnt    <= '0;
          end else begin
            if (y_in && (zero_count != CNT_MAX)) zero_count <= zero_count + CNT_W'(1);
`ifdef ZDC_LSB_FIRST_EN
            sreg    <= {1'b0, sreg[WIDTH-1:1]};
`else
            sreg    <= {sreg[WIDTH-2:0], 1'b0};
`endif
            bit_cnt <= bit_cnt - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ZDC_LSB_FIRST_EN
  assign x_out = (state == SHIFT) ? sreg[0] : 1'b0;
`else
  assign x_out = (state == SHIFT) ? sreg[WIDTH-1] : 1'b0;
`endif

  assign det_rst_n = t_reset & (state != CLR);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule
